wb_dma_master: RTL

//  Wishbone master DMA copy engine, arbiter master port 3 (lowest priority).

---
 rtl/wb_dma_master.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_dma_master.sv
// wb_dma_master: Wishbone DMA copy engine (lowest-priority arbiter master).
// Each chunk of up to BURST words is copied in two bus tenures: a read into a
// local buffer, then a write from it. The two are separated by a one-cycle
// idle gap so that higher-priority masters can take the bus in between.
module wb_dma_master #(
   parameter int BURST = 8,
   parameter int LEN_W = 16
) (
   input  logic             wb_clk,
   input  logic             wb_rst,
   input  logic             start,
   input  logic [29:0]      src_addr,
   input  logic [29:0]      dst_addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             cyc_o,
   output logic             stb_o,
   output logic [29:0]      addr_o,
   output logic [2:0]       cti_o,
   output logic [1:0]       bte_o,
   output logic [3:0]       sel_o,
   output logic             we_o,
   output logic [31:0]      data_o,
   input  logic [31:0]      data_i,
   input  logic             ack_i,
   input  logic             err_i
);

   // chunk/index counters must hold the value BURST; buffer index is log2(BURST)
   localparam int CW = $clog2(BURST + 1);
   localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [CW-1:0]    BURST_C = CW'(BURST);
   localparam logic [LEN_W-1:0] BURST_L = LEN_W'(BURST);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_FIN} state_t;

   state_t           r_state, w_state;
   logic [29:0]      r_src, w_src;
   logic [29:0]      r_dst, w_dst;
   logic [LEN_W-1:0] r_rem, w_rem;
   logic [CW-1:0]    r_chunk, w_chunk;
   logic [CW-1:0]    r_idx, w_idx;
   logic             r_rd_last, w_rd_last;
   logic             r_busy, w_busy;
   logic             r_done, w_done;
   logic             r_err, w_err;
   logic             r_cyc, w_cyc;
   logic             r_stb, w_stb;
   logic             r_we, w_we;
   logic [29:0]      r_addr, w_addr;
   logic [31:0]      r_data, w_data;
   logic [31:0]      r_buf [BURST];

   logic [CW-1:0]    w_len_chunk;
   logic [CW-1:0]    w_rem_chunk;
   logic [CW-1:0]    w_idx_inc;
   logic             w_last;
   logic             w_bus_err;
   logic             w_bus_ack;
   logic             w_buf_wr;

   // chunk size is min(BURST, words left); the short tail chunk falls out of this
   assign w_len_chunk = (len   >= BURST_L) ? BURST_C : len[CW-1:0];
   assign w_rem_chunk = (r_rem >= BURST_L) ? BURST_C : r_rem[CW-1:0];
   assign w_idx_inc   = r_idx + CW'(1);
   assign w_last      = (r_idx == (r_chunk - CW'(1)));
   // responses only count while a cycle is open; error beats acknowledge
   assign w_bus_err   = r_cyc & err_i;
   assign w_bus_ack   = r_cyc & ack_i & ~err_i;
   assign w_buf_wr    = (r_state == S_RD) & w_bus_ack;

   // state register
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) r_state <= S_IDLE;
      else         r_state <= w_state;
   end

   // next-state and next-output logic; every output is registered
   always_comb begin
      w_state   = r_state;
      w_src     = r_src;
      w_dst     = r_dst;
      w_rem     = r_rem;
      w_chunk   = r_chunk;
      w_idx     = r_idx;
      w_rd_last = r_rd_last;
      w_busy    = r_busy;
      w_done    = 1'b0;
      w_err     = r_err;
      w_cyc     = r_cyc;
      w_stb     = r_stb;
      w_we      = r_we;
      w_addr    = r_addr;
      w_data    = r_data;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_err = 1'b0;
               if (len != '0) begin
                  w_src     = src_addr;
                  w_dst     = dst_addr;
                  w_rem     = len;
                  w_chunk   = w_len_chunk;
                  w_idx     = '0;
                  w_rd_last = 1'b0;
                  w_busy    = 1'b1;
                  w_cyc     = 1'b1;
                  w_stb     = 1'b1;
                  w_we      = 1'b0;
                  w_addr    = src_addr;
                  w_state   = S_RD;
               end else begin
                  w_done = 1'b1;
               end
            end
         end
         S_RD: begin
            if (w_bus_err) begin
               w_cyc   = 1'b0;
               w_stb   = 1'b0;
               w_we    = 1'b0;
               w_err   = 1'b1;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_state = S_IDLE;
            end else if (w_bus_ack) begin
               w_src = r_src + 30'd1;
               w_idx = w_idx_inc;
               w_rem = r_rem - LEN_W'(1);
               if (w_last) begin
                  w_cyc     = 1'b0;
                  w_stb     = 1'b0;
                  w_idx     = '0;
                  w_rd_last = 1'b1;
                  w_state   = S_GAP;
               end else begin
                  w_addr = r_src + 30'd1;
               end
            end
         end
         S_GAP: begin
            // one idle cycle, then the other half of the chunk (or the next chunk)
            if (r_rd_last) begin
               w_rd_last = 1'b0;
               w_cyc     = 1'b1;
               w_stb     = 1'b1;
               w_we      = 1'b1;
               w_addr    = r_dst;
               w_data    = r_buf[0];
               w_state   = S_WR;
            end else begin
               w_chunk = w_rem_chunk;
               w_cyc   = 1'b1;
               w_stb   = 1'b1;
               w_we    = 1'b0;
               w_addr  = r_src;
               w_state = S_RD;
            end
         end
         S_WR: begin
            if (w_bus_err) begin
               w_cyc   = 1'b0;
               w_stb   = 1'b0;
               w_we    = 1'b0;
               w_err   = 1'b1;
               w_busy  = 1'b0;
               w_done  = 1'b1;
               w_state = S_IDLE;
            end else if (w_bus_ack) begin
               w_dst = r_dst + 30'd1;
               w_idx = w_idx_inc;
               if (w_last) begin
                  w_cyc = 1'b0;
                  w_stb = 1'b0;
                  w_we  = 1'b0;
                  w_idx = '0;
                  if (r_rem == '0) begin
                     w_busy  = 1'b0;
                     w_done  = 1'b1;
                     w_state = S_FIN;
                  end else begin
                     w_state = S_GAP;
                  end
               end else begin
                  w_addr = r_dst + 30'd1;
                  w_data = r_buf[w_idx_inc[IW-1:0]];
               end
            end
         end
         S_FIN: begin
            // done pulse is on during this cycle
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   // datapath and output registers
   always_ff @(posedge wb_clk or negedge wb_rst) begin
      if (!wb_rst) begin
         r_src     <= '0;
         r_dst     <= '0;
         r_rem     <= '0;
         r_chunk   <= '0;
         r_idx     <= '0;
         r_rd_last <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_cyc     <= 1'b0;
         r_stb     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
      end else begin
         r_src     <= w_src;
         r_dst     <= w_dst;
         r_rem     <= w_rem;
         r_chunk   <= w_chunk;
         r_idx     <= w_idx;
         r_rd_last <= w_rd_last;
         r_busy    <= w_busy;
         r_done    <= w_done;
         r_err     <= w_err;
         r_cyc     <= w_cyc;
         r_stb     <= w_stb;
         r_we      <= w_we;
         r_addr    <= w_addr;
         r_data    <= w_data;
      end
   end

   // chunk buffer: captured on each acknowledged read; contents need no reset
   always_ff @(posedge wb_clk) begin
      if (w_buf_wr) r_buf[r_idx[IW-1:0]] <= data_i;
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;
   assign cyc_o  = r_cyc;
   assign stb_o  = r_stb;
   assign we_o   = r_we;
   assign addr_o = r_addr;
   assign data_o = r_data;
   assign cti_o  = 3'b000;
   assign bte_o  = 2'b00;
   assign sel_o  = 4'hF;

endmodule
